// File: rtl/ascii_decimal_parser.sv
// ASCII decimal entry parser: buffers up to MAX_DIGITS digits from the UART
// receive path, then converts them to binary one digit per cycle.
module ascii_decimal_parser #(
    parameter int unsigned MAX_DIGITS = 4,
    parameter int unsigned OUT_W      = 14,
    parameter bit          FIXED_LEN  = 1'b0,
    parameter logic [7:0]  TERM_CHAR  = 8'h0D,
    parameter logic [7:0]  BS_CHAR    = 8'h08,
    parameter logic [7:0]  ABORT_CHAR = 8'h71
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [7:0]                         rx_byte,
    input  logic                               rx_valid,
    output logic [OUT_W-1:0]                   value,
    output logic                               value_valid,
    output logic [$clog2(MAX_DIGITS+1)-1:0]    digit_count,
    output logic                               busy,
    output logic                               error,
    output logic [1:0]                         err_code
);

    localparam int unsigned CW = $clog2(MAX_DIGITS + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCUM   = 2'd1,
        S_CONVERT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        buf_q [MAX_DIGITS];
    logic [3:0]        buf_d [MAX_DIGITS];
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     idx_q, idx_d;
    logic [OUT_W-1:0]  acc_q, acc_d;
    logic [OUT_W-1:0]  value_q, value_d;
    logic              value_valid_q, value_valid_d;
    logic              error_q, error_d;
    logic [1:0]        err_code_q, err_code_d;

    logic              is_digit, is_term, is_bs, is_abort;
    logic              cnt_full, cnt_last, conv_last;
    logic              append, drop, clear, finish, err_hit;
    logic [1:0]        err_cause;
    logic [3:0]        cur_digit;
    logic [OUT_W-1:0]  acc_step;

    assign is_digit  = (rx_byte >= 8'h30) && (rx_byte <= 8'h39);
    assign is_term   = (rx_byte == TERM_CHAR);
    assign is_bs     = (rx_byte == BS_CHAR);
    assign is_abort  = (rx_byte == ABORT_CHAR);
    assign cnt_full  = (cnt_q == CW'(MAX_DIGITS));
    assign cnt_last  = (cnt_q == CW'(MAX_DIGITS - 1));
    assign conv_last = (idx_q == cnt_q - CW'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Abort is tested first in every state; any error forces a return to IDLE.
    always_comb begin
        state_d   = state_q;
        append    = 1'b0;
        drop      = 1'b0;
        clear     = 1'b0;
        finish    = 1'b0;
        err_hit   = 1'b0;
        err_cause = 2'd0;
        case (state_q)
            S_IDLE: begin
                if (rx_valid && !is_abort) begin
                    if (is_digit) begin
                        append  = 1'b1;
                        state_d = (FIXED_LEN && cnt_last) ? S_CONVERT : S_ACCUM;
                    end else if (is_term) begin
                        err_hit   = 1'b1;
                        err_cause = 2'd3;
                    end else if (!is_bs) begin
                        err_hit   = 1'b1;
                        err_cause = 2'd1;
                    end
                end
            end
            S_ACCUM: begin
                if (rx_valid) begin
                    if (is_abort) begin
                        clear   = 1'b1;
                        state_d = S_IDLE;
                    end else if (is_digit) begin
                        if (cnt_full) begin
                            err_hit   = 1'b1;
                            err_cause = 2'd2;
                        end else begin
                            append = 1'b1;
                            if (FIXED_LEN && cnt_last) state_d = S_CONVERT;
                        end
                    end else if (is_bs) begin
                        drop = 1'b1;
                        if (cnt_q == CW'(1)) state_d = S_IDLE;
                    end else if (is_term && !FIXED_LEN) begin
                        state_d = S_CONVERT;
                    end else begin
                        err_hit   = 1'b1;
                        err_cause = 2'd1;
                    end
                end
            end
            S_CONVERT: begin
                if (rx_valid && is_abort) begin
                    clear   = 1'b1;
                    state_d = S_IDLE;
                end else if (conv_last) begin
                    finish  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (err_hit) begin
            clear   = 1'b1;
            state_d = S_IDLE;
        end
    end

    always_comb begin
        cur_digit = '0;
        for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
            if (idx_q == CW'(i)) cur_digit = buf_q[i];
        end
        acc_step = (acc_q << 3) + (acc_q << 1) + OUT_W'(cur_digit);

        buf_d         = buf_q;
        cnt_d         = cnt_q;
        value_d       = value_q;
        value_valid_d = 1'b0;
        error_d       = err_hit;
        err_code_d    = err_hit ? err_cause : err_code_q;

        if (clear || finish) begin
            for (int unsigned i = 0; i < MAX_DIGITS; i++) buf_d[i] = '0;
            cnt_d = '0;
        end else if (append) begin
            for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
                if (cnt_q == CW'(i)) buf_d[i] = rx_byte[3:0];
            end
            cnt_d = cnt_q + CW'(1);
        end else if (drop) begin
            for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
                if (cnt_q == CW'(i + 1)) buf_d[i] = '0;
            end
            cnt_d = cnt_q - CW'(1);
        end

        if (state_q == S_CONVERT) begin
            idx_d = idx_q + CW'(1);
            acc_d = acc_step;
        end else begin
            idx_d = '0;
            acc_d = '0;
        end

        // The final accumulate step is written straight to value so the result
        // appears on the same edge that leaves CONVERT.
        if (finish) begin
            value_d       = acc_step;
            value_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_q         <= '{default: '0};
            cnt_q         <= '0;
            idx_q         <= '0;
            acc_q         <= '0;
            value_q       <= '0;
            value_valid_q <= 1'b0;
            error_q       <= 1'b0;
            err_code_q    <= '0;
        end else begin
            buf_q         <= buf_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            acc_q         <= acc_d;
            value_q       <= value_d;
            value_valid_q <= value_valid_d;
            error_q       <= error_d;
            err_code_q    <= err_code_d;
        end
    end

    always_comb begin
        value       = value_q;
        value_valid = value_valid_q;
        digit_count = cnt_q;
        busy        = (state_q == S_CONVERT);
        error       = error_q;
        err_code    = err_code_q;
    end

endmodule

// File: tb/tb_ascii_decimal_parser.sv
// Bench for ascii_decimal_parser: a terminated-entry instance (4 digits) and a
// fixed-length instance (3 digits), directed scenarios plus a randomized run.
module tb_ascii_decimal_parser;

    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] BS = 8'h08;
    localparam logic [7:0] QC = 8'h71;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_byte0, rx_byte1;
    logic        rx_valid0, rx_valid1;

    logic [13:0] value0;
    logic        vv0, busy0, err0;
    logic [2:0]  cnt0;
    logic [1:0]  code0;

    logic [9:0]  value1;
    logic        vv1, busy1, err1;
    logic [1:0]  cnt1;
    logic [1:0]  code1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ascii_decimal_parser #(
        .MAX_DIGITS(4), .OUT_W(14), .FIXED_LEN(1'b0),
        .TERM_CHAR(8'h0D), .BS_CHAR(8'h08), .ABORT_CHAR(8'h71)
    ) dut0 (
        .clk(clk), .rst(rst), .rx_byte(rx_byte0), .rx_valid(rx_valid0),
        .value(value0), .value_valid(vv0), .digit_count(cnt0),
        .busy(busy0), .error(err0), .err_code(code0)
    );

    ascii_decimal_parser #(
        .MAX_DIGITS(3), .OUT_W(10), .FIXED_LEN(1'b1),
        .TERM_CHAR(8'h0D), .BS_CHAR(8'h08), .ABORT_CHAR(8'h71)
    ) dut1 (
        .clk(clk), .rst(rst), .rx_byte(rx_byte1), .rx_valid(rx_valid1),
        .value(value1), .value_valid(vv1), .digit_count(cnt1),
        .busy(busy1), .error(err1), .err_code(code1)
    );

    // Reference model state: the digit buffer as a queue, conversion countdown.
    int  mq0[$];
    int  mq1[$];
    bit  m_conv[2];
    int  m_left[2];
    int  m_pend[2];
    int  e_value[2];
    bit  e_vv[2];
    bit  e_err[2];
    int  e_code[2];
    int  e_cnt[2];
    bit  e_busy[2];

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int sel, input logic [7:0] b);
        if (sel == 0) begin rx_byte0 = b; rx_valid0 = 1'b1; end
        else          begin rx_byte1 = b; rx_valid1 = 1'b1; end
        @(posedge clk);
        #1;
        rx_valid0 = 1'b0;
        rx_valid1 = 1'b0;
    endtask

    // Cycles from the strobe that started conversion to value_valid; -1 on timeout.
    task automatic wait_vv(input int sel, output int lat);
        lat = 1;
        for (int k = 0; k < 30; k++) begin
            idle_cycle();
            lat++;
            if ((sel == 0 && vv0 === 1'b1) || (sel == 1 && vv1 === 1'b1)) return;
        end
        lat = -1;
    endtask

    task automatic model_reset();
        mq0.delete();
        mq1.delete();
        for (int s = 0; s < 2; s++) begin
            m_conv[s] = 0; m_left[s] = 0; m_pend[s] = 0;
            e_value[s] = 0; e_vv[s] = 0; e_err[s] = 0;
            e_code[s] = 0; e_cnt[s] = 0; e_busy[s] = 0;
        end
    endtask

    task automatic model_step(input int sel, input bit v, input logic [7:0] b);
        int q[$];
        int maxd;
        bit fixed;
        bit start;
        int cause;
        if (sel == 0) q = mq0; else q = mq1;
        maxd  = (sel == 0) ? 4 : 3;
        fixed = (sel == 1);
        start = 0;
        cause = 0;
        e_vv[sel]  = 0;
        e_err[sel] = 0;
        if (m_conv[sel]) begin
            if (v && b == QC) begin
                m_conv[sel] = 0;
                q.delete();
            end else begin
                m_left[sel]--;
                if (m_left[sel] == 0) begin
                    e_value[sel] = m_pend[sel];
                    e_vv[sel]    = 1;
                    m_conv[sel]  = 0;
                    q.delete();
                end
            end
        end else if (v) begin
            if (b == QC) q.delete();
            else if (b >= 8'h30 && b <= 8'h39) begin
                if (q.size() == maxd) cause = 2;
                else begin
                    q.push_back(int'(b) - 48);
                    if (fixed && q.size() == maxd) start = 1;
                end
            end else if (b == BS) begin
                if (q.size() > 0) q.delete(q.size() - 1);
            end else if (b == CR) begin
                if (q.size() == 0) cause = 3;
                else if (fixed)    cause = 1;
                else               start = 1;
            end else cause = 1;
        end
        if (cause != 0) begin
            e_err[sel]  = 1;
            e_code[sel] = cause;
            q.delete();
        end
        if (start) begin
            m_conv[sel] = 1;
            m_left[sel] = q.size();
            m_pend[sel] = 0;
            foreach (q[i]) m_pend[sel] = m_pend[sel] * 10 + q[i];
        end
        e_cnt[sel]  = q.size();
        e_busy[sel] = m_conv[sel];
        if (sel == 0) mq0 = q; else mq1 = q;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        rx_valid0 = 1'b0; rx_valid1 = 1'b0;
        rx_byte0 = '0; rx_byte1 = '0;
        repeat (2) idle_cycle();
        n_checks++; if (value0 !== 14'd0) begin n_fail++; $display("FAIL reset_value0: got %0d want 0", value0); end
        n_checks++; if (cnt0 !== 3'd0) begin n_fail++; $display("FAIL reset_cnt0: got %0d want 0", cnt0); end
        n_checks++; if ({vv0, busy0, err0, code0} !== 5'b0) begin n_fail++; $display("FAIL reset_flags0: got %b want 00000", {vv0, busy0, err0, code0}); end
        n_checks++; if ({value1, cnt1, vv1, busy1, err1, code1} !== 17'b0) begin n_fail++; $display("FAIL reset_dut1: got %h want 0", {value1, cnt1, vv1, busy1, err1, code1}); end
        @(negedge clk) rst = 1'b1;
        idle_cycle();
    endtask

    task automatic test_basic();
        int lat;
        for (int i = 0; i < 3; i++) begin
            send(0, 8'h31 + 8'(i));
            n_checks++; if (cnt0 !== 3'(i + 1)) begin n_fail++; $display("FAIL basic_cnt: got %0d want %0d", cnt0, i + 1); end
        end
        send(0, CR);
        n_checks++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b want 1", busy0); end
        wait_vv(0, lat);
        n_checks++; if (lat != 4) begin n_fail++; $display("FAIL basic_latency: got %0d want 4", lat); end
        n_checks++; if (value0 !== 14'd123) begin n_fail++; $display("FAIL basic_value: got %0d want 123", value0); end
        n_checks++; if ({cnt0, busy0, err0} !== 5'b0) begin n_fail++; $display("FAIL basic_done_state: got %b want 00000", {cnt0, busy0, err0}); end
        idle_cycle();
        n_checks++; if (vv0 !== 1'b0) begin n_fail++; $display("FAIL basic_vv_pulse: got %b want 0", vv0); end
    endtask

    task automatic test_backspace();
        int lat;
        send(0, 8'h39); send(0, 8'h38); send(0, BS);
        n_checks++; if (cnt0 !== 3'd1) begin n_fail++; $display("FAIL bs_cnt: got %0d want 1", cnt0); end
        send(0, 8'h37); send(0, CR);
        wait_vv(0, lat);
        n_checks++; if (lat != 3) begin n_fail++; $display("FAIL bs_latency: got %0d want 3", lat); end
        n_checks++; if (value0 !== 14'd97) begin n_fail++; $display("FAIL bs_value: got %0d want 97", value0); end
        send(0, 8'h35); send(0, BS);
        n_checks++; if ({cnt0, err0} !== 4'b0) begin n_fail++; $display("FAIL bs_to_idle: got %b want 0000", {cnt0, err0}); end
        send(0, BS);
        n_checks++; if ({cnt0, err0} !== 4'b0) begin n_fail++; $display("FAIL bs_in_idle: got %b want 0000", {cnt0, err0}); end
        send(0, CR);
        n_checks++; if ({err0, code0} !== 3'b111) begin n_fail++; $display("FAIL empty_term: got err=%b code=%0d want err=1 code=3", err0, code0); end
        idle_cycle();
        n_checks++; if ({err0, code0} !== 3'b011) begin n_fail++; $display("FAIL err_held: got err=%b code=%0d want err=0 code=3", err0, code0); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 4; i++) send(0, 8'h31 + 8'(i));
        n_checks++; if (cnt0 !== 3'd4) begin n_fail++; $display("FAIL ovf_full: got %0d want 4", cnt0); end
        send(0, 8'h35);
        n_checks++; if ({err0, code0} !== 3'b110) begin n_fail++; $display("FAIL ovf_err: got err=%b code=%0d want err=1 code=2", err0, code0); end
        n_checks++; if (value0 !== 14'd97) begin n_fail++; $display("FAIL ovf_value_kept: got %0d want 97", value0); end
        n_checks++; if ({cnt0, vv0} !== 4'b0) begin n_fail++; $display("FAIL ovf_cleared: got %b want 0000", {cnt0, vv0}); end
        send(0, 8'h34); send(0, 8'h78);
        n_checks++; if ({err0, code0, cnt0} !== 6'b101_000) begin n_fail++; $display("FAIL nondigit_err: got %b want 101000", {err0, code0, cnt0}); end
    endtask

    task automatic test_abort();
        int pulses;
        send(0, 8'h35); send(0, 8'h36); send(0, CR);
        idle_cycle();
        send(0, QC);
        n_checks++; if ({busy0, cnt0} !== 4'b0) begin n_fail++; $display("FAIL abort_conv_state: got %b want 0000", {busy0, cnt0}); end
        pulses = (vv0 === 1'b1) ? 1 : 0;
        repeat (6) begin idle_cycle(); if (vv0 === 1'b1) pulses++; end
        n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL abort_no_vv: got %0d want 0", pulses); end
        n_checks++; if (value0 !== 14'd97) begin n_fail++; $display("FAIL abort_value_kept: got %0d want 97", value0); end
        send(0, 8'h37); send(0, 8'h37); send(0, QC);
        n_checks++; if ({cnt0, err0, busy0} !== 5'b0) begin n_fail++; $display("FAIL abort_accum: got %b want 00000", {cnt0, err0, busy0}); end
    endtask

    task automatic test_fixed();
        int lat;
        send(1, 8'h30); send(1, 8'h34);
        n_checks++; if ({cnt1, busy1} !== 3'b100) begin n_fail++; $display("FAIL fixed_accum: got %b want 100", {cnt1, busy1}); end
        send(1, 8'h32);
        n_checks++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL fixed_autostart: got %b want 1", busy1); end
        wait_vv(1, lat);
        n_checks++; if (lat != 4) begin n_fail++; $display("FAIL fixed_latency: got %0d want 4", lat); end
        n_checks++; if (value1 !== 10'd42) begin n_fail++; $display("FAIL fixed_value42: got %0d want 42", value1); end
        for (int i = 0; i < 3; i++) send(1, 8'h39);
        wait_vv(1, lat);
        n_checks++; if (value1 !== 10'd999) begin n_fail++; $display("FAIL fixed_value999: got %0d want 999", value1); end
        send(1, 8'h31); send(1, CR);
        n_checks++; if ({err1, code1, cnt1} !== 5'b101_00) begin n_fail++; $display("FAIL fixed_term_err: got %b want 10100", {err1, code1, cnt1}); end
    endtask

    task automatic test_reset_convert();
        int pulses;
        int lat;
        for (int i = 0; i < 4; i++) send(0, 8'h38);
        send(0, CR);
        idle_cycle(); idle_cycle();
        #2 rst = 1'b0;
        #1;
        n_checks++; if ({value0, vv0, cnt0, busy0, err0, code0} !== 22'b0) begin n_fail++; $display("FAIL async_reset: got %h want 0", {value0, vv0, cnt0, busy0, err0, code0}); end
        @(negedge clk) rst = 1'b1;
        pulses = 0;
        repeat (8) begin idle_cycle(); if (vv0 === 1'b1 || err0 === 1'b1) pulses++; end
        n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL reset_no_pulse: got %0d want 0", pulses); end
        send(0, 8'h33); send(0, CR);
        wait_vv(0, lat);
        n_checks++; if (lat != 2) begin n_fail++; $display("FAIL post_reset_latency: got %0d want 2", lat); end
        n_checks++; if (value0 !== 14'd3) begin n_fail++; $display("FAIL post_reset_value: got %0d want 3", value0); end
    endtask

    function automatic logic [7:0] rand_byte();
        int r;
        r = $urandom_range(0, 99);
        if (r < 60)      return 8'h30 + 8'($urandom_range(0, 9));
        else if (r < 70) return BS;
        else if (r < 80) return CR;
        else if (r < 84) return QC;
        else             return 8'($urandom_range(0, 255));
    endfunction

    task automatic test_random();
        bit         v [2];
        logic [7:0] b [2];
        logic [31:0] a_val, a_vv, a_err, a_code, a_cnt, a_busy;
        rst = 1'b0;
        idle_cycle();
        @(negedge clk) rst = 1'b1;
        idle_cycle();
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int s = 0; s < 2; s++) begin
                v[s] = ($urandom_range(0, 3) != 0);
                b[s] = rand_byte();
                model_step(s, v[s], b[s]);
            end
            rx_valid0 = v[0]; rx_byte0 = b[0];
            rx_valid1 = v[1]; rx_byte1 = b[1];
            idle_cycle();
            for (int s = 0; s < 2; s++) begin
                a_val  = (s == 0) ? 32'(value0) : 32'(value1);
                a_vv   = (s == 0) ? 32'(vv0)    : 32'(vv1);
                a_err  = (s == 0) ? 32'(err0)   : 32'(err1);
                a_code = (s == 0) ? 32'(code0)  : 32'(code1);
                a_cnt  = (s == 0) ? 32'(cnt0)   : 32'(cnt1);
                a_busy = (s == 0) ? 32'(busy0)  : 32'(busy1);
                n_checks++; if (a_val !== 32'(e_value[s])) begin n_fail++; $display("FAIL rand_value dut%0d cyc %0d: got %0d want %0d", s, cyc, a_val, e_value[s]); end
                n_checks++; if (a_vv !== 32'(e_vv[s])) begin n_fail++; $display("FAIL rand_vv dut%0d cyc %0d: got %0d want %0d", s, cyc, a_vv, e_vv[s]); end
                n_checks++; if (a_err !== 32'(e_err[s])) begin n_fail++; $display("FAIL rand_err dut%0d cyc %0d: got %0d want %0d", s, cyc, a_err, e_err[s]); end
                n_checks++; if (a_code !== 32'(e_code[s])) begin n_fail++; $display("FAIL rand_code dut%0d cyc %0d: got %0d want %0d", s, cyc, a_code, e_code[s]); end
                n_checks++; if (a_cnt !== 32'(e_cnt[s])) begin n_fail++; $display("FAIL rand_cnt dut%0d cyc %0d: got %0d want %0d", s, cyc, a_cnt, e_cnt[s]); end
                n_checks++; if (a_busy !== 32'(e_busy[s])) begin n_fail++; $display("FAIL rand_busy dut%0d cyc %0d: got %0d want %0d", s, cyc, a_busy, e_busy[s]); end
            end
        end
        rx_valid0 = 1'b0;
        rx_valid1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backspace();
        test_overflow();
        test_abort();
        test_fixed();
        test_reset_convert();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/ascii_decimal_parser.md
Name: ascii_decimal_parser

Overview:
- Parametrised successor of the fixed 3-digit ASCII-to-binary accumulator.
- Collects ASCII decimal digits from the UART receive path, one byte per `rx_valid` strobe, into a digit buffer.
- Supports backspace, abort, and terminated or fixed-length entry.
- On completion it converts the buffer to binary serially (one digit per cycle) and presents the result to the ATM control FSM with a one-cycle valid pulse. Error pulses carry a cause code.

Parameters:
- MAX_DIGITS, 4, maximum digits held in the buffer (1..8).
- OUT_W, 14, result width. Must satisfy 2^OUT_W > 10^MAX_DIGITS - 1; this is an integration constraint and is not checked in RTL.
- FIXED_LEN, 0, 0 = entry ends on TERM_CHAR; 1 = conversion starts automatically when the MAX_DIGITS-th digit is accepted.
- TERM_CHAR, 8'h0D, terminator byte (carriage return).
- BS_CHAR, 8'h08, backspace byte.
- ABORT_CHAR, 8'h71, abort byte ('q').

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- rx_byte  in  8  received ASCII byte; sampled only when rx_valid=1.
- rx_valid  in  1  one-cycle strobe from the UART receiver (byte received properly).
- value  out  OUT_W  last converted binary result; held until the next successful conversion.
- value_valid  out  1  one-cycle pulse when value updates.
- digit_count  out  $clog2(MAX_DIGITS+1)  digits currently buffered (drives echo/masking for PIN entry).
- busy  out  1  high in CONVERT state.
- error  out  1  one-cycle pulse on a rejected entry.
- err_code  out  2  cause, valid with error and held until the next error: 1 = non-digit byte, 2 = digit overflow, 3 = empty terminate.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; buffer and digit_count cleared.
  - value=0, value_valid=0, error=0, err_code=0, busy=0.
- States: IDLE, ACCUM, CONVERT.
- Digits: bytes 8'h30..8'h39 are digits; the stored digit is rx_byte-8'h30 (4 bits).
- IDLE:
  - A digit is stored in slot 0, digit_count=1, go to ACCUM.
  - TERM_CHAR gives error code 3.
  - BS_CHAR and ABORT_CHAR are ignored.
  - Any other byte gives error code 1.
- ACCUM, on rx_valid:
  - Digit with digit_count<MAX_DIGITS: append and increment the count. If FIXED_LEN=1 and the new count equals MAX_DIGITS, go to CONVERT on the next cycle.
  - Digit with digit_count==MAX_DIGITS (FIXED_LEN=0 only): error code 2.
  - BS_CHAR: drop the last digit and decrement the count. If the count reaches 0, return to IDLE with no error.
  - TERM_CHAR (FIXED_LEN=0): go to CONVERT. With FIXED_LEN=1, TERM_CHAR gives error code 1.
  - ABORT_CHAR: clear the buffer, go to IDLE, no pulse.
  - Other byte: error code 1.
- Error action:
  - error=1 for one cycle and err_code is set.
  - Buffer and count are cleared, state goes to IDLE.
  - value is unchanged.
- CONVERT:
  - acc starts at 0. Each cycle, acc = acc*10 + digit[i], taken oldest first. Use OUT_W-bit arithmetic; shift-add (x8 + x2) is acceptable.
  - After digit_count cycles, value=acc and value_valid=1 in the following cycle.
  - On the same edge: buffer cleared, state goes to IDLE, busy drops.
- Latency: from the rx_valid of the terminator (or the last digit in FIXED_LEN mode) to value_valid is digit_count+1 cycles.
- rx_valid during CONVERT:
  - The byte is ignored with no error.
  - Exception: ABORT_CHAR cancels the conversion (to IDLE, no value_valid, value unchanged).
- ABORT_CHAR in any state has priority over all other decoding.
- value_valid and error are never high in the same cycle.
- Reset asserted mid-entry or mid-conversion: immediate return to reset values. No pulse is emitted after release.
- rx_valid held high on consecutive cycles: each cycle is a separate byte, no handshake back-pressure.

Test Plan:
- FIXED_LEN=0, MAX_DIGITS=4: send "1","2","3",CR -> value=123 and value_valid pulse exactly 4 cycles after CR strobe; digit_count 1,2,3 then 0.
- Send "9","8",BS,"7",CR -> value=97; BS,BS after "5" returns to IDLE with no error, then CR -> error, err_code=3.
- Send "1","2","3","4","5" -> error on 5th digit, err_code=2, value keeps previous result (97); "4","x" -> error, err_code=1.
- FIXED_LEN=1, MAX_DIGITS=3: send "0","4","2" with no terminator -> value=42 after 4 cycles; "9","9","9" -> value=999.
- Send "5","6",CR then 'q' during CONVERT -> no value_valid, value unchanged, state IDLE; 'q' mid-ACCUM clears digit_count to 0 with no pulse.
- Assert rst low asynchronously (off clock edge) during CONVERT of "8888" -> all outputs 0 immediately; after release, "3",CR -> value=3.
